// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button/switch inputs and count/display outputs of stopwatch_ctrl.
interface stopwatch_ctrl_if;
   logic [1:0]  KEY;
   logic        SW;
   logic [15:0] Q;
   logic [15:0] Display;
   logic        running;
   logic        wrap;
   modport master (output KEY, SW, input Q, Display, running, wrap);
   modport slave (input KEY, SW, output Q, Display, running, wrap);
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear controller for a 4-digit BCD stopwatch (SS.cc, 00.00-59.99).
// Define STOPWATCH_LAP_EN to build the lap-hold register; otherwise Display simply follows Q.
module stopwatch_ctrl #(
   parameter int CLK_HZ          = 50000000,
   parameter int TICK_HZ         = 100,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic             clk_50M,
   input logic             reset,
   stopwatch_ctrl_if.slave bus
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   state_t        state_q, state_d;
   logic [1:0]    s1_q, s1_d, s2_q, s2_d, db_q, db_d;
   logic [1:0]    arm_q, arm_d, press_q, press_d, vld_q, vld_d;
   logic [DW-1:0] cnt_q [2];
   logic [DW-1:0] cnt_d [2];
   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   q_q, q_d, disp_q, disp_d;
   logic          running_q, running_d, wrap_q, wrap_d;
   logic          start, lap_ev, tick, c1, c2, c3;

   // Synchronize, debounce and edge-detect both buttons; a button is armed only once
   // it has been seen released, so one held through reset produces no press
   always_comb begin
      s1_d  = bus.KEY;
      s2_d  = s1_q;
      vld_d = {vld_q[0], 1'b1};
      db_d  = db_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = (s2_q[i] != db_q[i]) ? cnt_q[i] + 1'b1 : '0;
         if (s2_q[i] != db_q[i] && cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            db_d[i]  = s2_q[i];
            cnt_d[i] = '0;
         end
      end
      arm_d   = arm_q | (s2_q & {2{vld_q[1]}});
      press_d = arm_q & db_q & ~db_d;
   end

   // Prescaler, BCD digit cascade and run/pause/clear sequencing; start beats lap
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      q_d     = q_q;
      start   = press_q[0];
      lap_ev  = press_q[1] & ~press_q[0];
      tick    = state_q == RUN && bus.SW && pre_q == PW'(DIV - 1);
      c1      = q_q[3:0] == 4'd9;
      c2      = c1 && q_q[7:4] == 4'd9;
      c3      = c2 && q_q[11:8] == 4'd9;
      if (state_q == RUN && bus.SW) pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
         q_d[3:0]   = c1 ? 4'd0 : q_q[3:0] + 4'd1;
         q_d[7:4]   = c1 ? (c2 ? 4'd0 : q_q[7:4] + 4'd1) : q_q[7:4];
         q_d[11:8]  = c2 ? (c3 ? 4'd0 : q_q[11:8] + 4'd1) : q_q[11:8];
         q_d[15:12] = c3 ? (q_q[15:12] == 4'd5 ? 4'd0 : q_q[15:12] + 4'd1) : q_q[15:12];
      end
      wrap_d = tick && q_q == 16'h5999;
      case (state_q)
         IDLE:    if (start && bus.SW) state_d = RUN;
         RUN:     if (start) state_d = PAUSE;
         PAUSE:   if (start && bus.SW) state_d = RUN;
                  else if (lap_ev) begin
                     state_d = IDLE;
                     q_d     = '0;
                     pre_d   = '0;
                  end
         default: state_d = IDLE;
      endcase
      running_d = state_d == RUN;
   end

`ifdef STOPWATCH_LAP_EN
   logic        lap_hold_q, lap_hold_d;
   logic [15:0] lap_q, lap_d;
   // Lap toggles the hold in RUN, capturing Q when set; leaving RUN drops the hold
   always_comb begin
      lap_hold_d = state_d == RUN && (state_q == RUN && lap_ev ? ~lap_hold_q : lap_hold_q);
      lap_d      = state_q == RUN && lap_ev && !lap_hold_q ? q_q : lap_q;
      disp_d     = lap_hold_q ? lap_q : q_q;
   end
   // Lap hold and snapshot registers
   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         lap_hold_q <= 1'b0;
         lap_q      <= '0;
      end else begin
         lap_hold_q <= lap_hold_d;
         lap_q      <= lap_d;
      end
   end
`else
   // Display follows the live count one cycle late
   always_comb disp_d = q_q;
`endif

   // Input path, FSM, count and output registers
   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         s1_q      <= '1;
         s2_q      <= '1;
         db_q      <= '1;
         vld_q     <= '0;
         arm_q     <= '0;
         press_q   <= '0;
         cnt_q[0]  <= '0;
         cnt_q[1]  <= '0;
         state_q   <= IDLE;
         pre_q     <= '0;
         q_q       <= '0;
         disp_q    <= '0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         db_q      <= db_d;
         vld_q     <= vld_d;
         arm_q     <= arm_d;
         press_q   <= press_d;
         cnt_q[0]  <= cnt_d[0];
         cnt_q[1]  <= cnt_d[1];
         state_q   <= state_d;
         pre_q     <= pre_d;
         q_q       <= q_d;
         disp_q    <= disp_d;
         running_q <= running_d;
         wrap_q    <= wrap_d;
      end
   end

   assign bus.Q       = q_q;
   assign bus.Display = disp_q;
   assign bus.running = running_q;
   assign bus.wrap    = wrap_q;
endmodule
